// File: rtl/hash_target_checker_if.sv
// Bus bundle for hash_target_checker: run control, memory read port and
// result outputs. The DUT takes the slave view, the bench drives the master.
interface hash_target_checker_if #(
    parameter int IDX_W = 4
) ();
    // run control
    logic             start;
    logic [15:0]      hash_addr;
    logic [31:0]      target;

    // memory read port
    logic             mem_clk;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [31:0]      mem_read_data;

    // results
    logic             done;
    logic             found;
    logic [IDX_W-1:0] nonce_idx;
    logic [31:0]      min_hash;
    logic [IDX_W-1:0] min_idx;

    modport slave (
        input  start, hash_addr, target, mem_read_data,
        output mem_clk, mem_we, mem_addr,
        output done, found, nonce_idx, min_hash, min_idx
    );

    modport master (
        output start, hash_addr, target, mem_read_data,
        input  mem_clk, mem_we, mem_addr,
        input  done, found, nonce_idx, min_hash, min_idx
    );
endinterface

// File: rtl/hash_target_checker.sv
// Scans NUM_NONCES consecutive 32-bit hash words from a synchronous memory,
// reporting the first word strictly below target and the smallest word seen.
//
// Handshake: start is a single-cycle request that is accepted only in IDLE
// or DONE; there is no ready output, a start seen in ADDR/WAIT/CMP is simply
// dropped. done is a level that stays high from the end of the scan until
// the next accepted start or reset.
module hash_target_checker #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    hash_target_checker_if.slave bus,
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      base_q;
    logic [31:0]      target_q;
    logic [15:0]      mem_addr_q;
    logic             done_q;
    logic             found_q;
    logic [IDX_W-1:0] nonce_idx_q;
    logic [31:0]      min_hash_q;
    logic [IDX_W-1:0] min_idx_q;

    // Scan FSM: one three-cycle slot per word (issue address, wait for the
    // synchronous read, compare); all results are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            target_q    <= '0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            nonce_idx_q <= '0;
            min_hash_q  <= '0;
            min_idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        base_q      <= bus.hash_addr;
                        target_q    <= bus.target;
                        idx_q       <= '0;
                        found_q     <= 1'b0;
                        nonce_idx_q <= '0;
                        min_hash_q  <= '1;
                        min_idx_q   <= '0;
                        done_q      <= 1'b0;
                        state_q     <= ADDR;
                    end
                end
                ADDR: begin
                    // 16-bit add wraps naturally past 0xFFFF
                    mem_addr_q <= base_q + 16'(idx_q);
                    state_q    <= WAIT;
                end
                WAIT: begin
                    state_q <= CMP;
                end
                CMP: begin
                    // strict compares: a tie never displaces an earlier index
                    if ((bus.mem_read_data < target_q) && !found_q) begin
                        found_q     <= 1'b1;
                        nonce_idx_q <= idx_q;
                    end
                    if (bus.mem_read_data < min_hash_q) begin
                        min_hash_q <= bus.mem_read_data;
                        min_idx_q  <= idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ADDR;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_clk   = clk;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.done      = done_q;
    assign bus.found     = found_q;
    assign bus.nonce_idx = nonce_idx_q;
    assign bus.min_hash  = min_hash_q;
    assign bus.min_idx   = min_idx_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hash_target_checker.sv
// Self-checking bench for hash_target_checker: a memory model serves the
// hash words, expected results are queued at start and compared at done.
module tb_hash_target_checker;

    localparam int N = 16;
    localparam int W = 41;  // {found, nonce_idx[3:0], min_hash[31:0], min_idx[3:0]}

    logic       clk;
    logic       reset;
    logic [2:0] dbg_state;

    hash_target_checker_if #(.IDX_W(4)) bus ();

    hash_target_checker #(.NUM_NONCES(N), .IDX_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- synchronous memory model ----------------
    logic [31:0] mem [0:65535];
    logic [31:0] rd_q;
    always @(posedge clk) rd_q <= mem[bus.mem_addr];
    assign bus.mem_read_data = rd_q;

    // ---------------- scoreboard state ----------------
    logic [31:0]  hw [0:N-1];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] last_exp;
    logic [15:0]  cur_base;
    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [15:0] base, input logic [31:0] tgt);
        logic        f;
        logic [3:0]  ni;
        logic [31:0] mh;
        logic [3:0]  mi;
        for (int k = 0; k < N; k++) mem[16'(base + 16'(k))] = hw[k];
        f = 1'b0; ni = '0; mh = 32'hFFFF_FFFF; mi = '0;
        for (int k = 0; k < N; k++) begin
            if (hw[k] < tgt && !f) begin f = 1'b1; ni = 4'(k); end
            if (hw[k] < mh) begin mh = hw[k]; mi = 4'(k); end
        end
        exp_q.push_back({f, ni, mh, mi});
        cur_base      = base;
        bus.hash_addr = base;
        bus.target    = tgt;
        bus.start     = 1'b1;
        @(posedge clk);  // edge 0
        #1;
        bus.start = 1'b0;
    endtask

    // Called just after edge 0. chk_addr checks the address sequence,
    // poke injects starts at edges 5 and 30 plus input changes mid-run.
    task automatic wait_done(input bit chk_addr, input bit poke);
        int done_edge;
        int addr_err;
        int we_err;
        logic [W-1:0] e;
        done_edge = -1; addr_err = 0; we_err = 0;
        for (int ed = 1; ed <= 200; ed++) begin
            if (poke && (ed == 5 || ed == 30)) begin
                bus.start     = 1'b1;
                bus.hash_addr = 16'($urandom);
                bus.target    = $urandom;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.mem_we !== 1'b0) we_err++;
            if (chk_addr && ed < 3 * N && (ed % 3) != 0)
                if (bus.mem_addr !== 16'(cur_base + 16'((ed - 1) / 3))) addr_err++;
            if (bus.done === 1'b1) begin
                done_edge = ed;
                break;
            end
        end
        check("done_edge", 32'(done_edge), 32'(3 * N));
        check("mem_we_zero", 32'(we_err), 0);
        if (chk_addr) check("addr_seq", 32'(addr_err), 0);
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            last_exp = e;
            check("found",     {31'd0, bus.found},     {31'd0, e[40]});
            check("nonce_idx", {28'd0, bus.nonce_idx}, {28'd0, e[39:36]});
            check("min_hash",  bus.min_hash,           e[35:4]);
            check("min_idx",   {28'd0, bus.min_idx},   {28'd0, e[3:0]});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"},      {31'd0, bus.done},      0);
        check({tag, "_found"},     {31'd0, bus.found},     0);
        check({tag, "_nonce_idx"}, {28'd0, bus.nonce_idx}, 0);
        check({tag, "_min_hash"},  bus.min_hash,           0);
        check({tag, "_min_idx"},   {28'd0, bus.min_idx},   0);
        check({tag, "_mem_addr"},  {16'd0, bus.mem_addr},  0);
        check({tag, "_state"},     {29'd0, dbg_state},     0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.start = 1'b0; bus.hash_addr = '0; bus.target = '0;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_BEEF;
        reset = 1'b1;
        #2;
        check_zero("reset");  // before any clock edge
        check("mem_we_reset", {31'd0, bus.mem_we}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // all words max: nothing found, min stays at all-ones, index 0
        for (int k = 0; k < N; k++) hw[k] = 32'hFFFF_FFFF;
        start_run(16'h0100, 32'h0001_0000);
        wait_done(1'b1, 1'b0);

        // first hit at 5, minimum at 9
        for (int k = 0; k < N; k++) hw[k] = 32'h8000_0000;
        hw[5] = 32'h0000_FFFF;
        hw[9] = 32'h0000_0001;
        start_run(16'h2000, 32'h0001_0000);
        wait_done(1'b1, 1'b0);

        // word equal to target is not a hit
        for (int k = 0; k < N; k++) hw[k] = 32'h0000_2000 + 32'(k);
        hw[3] = 32'h0000_1000;
        start_run(16'h3000, 32'h0000_1000);
        wait_done(1'b1, 1'b0);

        // ties: minimum keeps the lowest index
        for (int k = 0; k < N; k++) hw[k] = 32'h0000_0500;
        start_run(16'h3100, 32'h0000_0600);
        wait_done(1'b0, 1'b0);

        // address wrap past 0xFFFF
        for (int k = 0; k < N; k++) hw[k] = $urandom;
        start_run(16'hFFF8, 32'h4000_0000);
        wait_done(1'b1, 1'b0);

        // results hold in DONE
        repeat (5) @(posedge clk);
        #1;
        check("hold_done",     {31'd0, bus.done},  1);
        check("hold_min_hash", bus.min_hash,       last_exp[35:4]);
        check("hold_state",    {29'd0, dbg_state}, 4);

        // reset mid-run aborts; next run is clean
        for (int k = 0; k < N; k++) hw[k] = $urandom_range(1000, 0);
        start_run(16'h4000, 32'd500);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_zero("abort");
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) hw[k] = $urandom_range(1000, 0);
        start_run(16'h4100, 32'd300);
        wait_done(1'b1, 1'b0);

        // starts and input changes mid-run are ignored
        for (int k = 0; k < N; k++) hw[k] = $urandom;
        start_run(16'h5000, 32'h2000_0000);
        wait_done(1'b1, 1'b1);

        // start in DONE clears done on that edge; second run correct
        for (int k = 0; k < N; k++) hw[k] = $urandom;
        hw[12] = 32'h0000_0007;
        start_run(16'h6000, 32'h0000_0100);
        check("done_cleared", {31'd0, bus.done}, 0);
        wait_done(1'b1, 1'b0);

        // random runs
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++)
                hw[k] = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(65535, 0)) : $urandom;
            start_run(16'($urandom), 32'($urandom_range(100000, 0)));
            wait_done(1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_target_checker.md
HASH_TARGET_CHECKER -- requirements
Module: hash_target_checker

Interface
REQ-001 The block SHALL have parameter NUM_NONCES, default 16, giving the number of consecutive 32-bit hash words scanned per run.
REQ-002 The block SHALL have parameter IDX_W, default 4, giving the width of the index outputs; it SHALL satisfy 2^IDX_W >= NUM_NONCES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-006 The block SHALL have port hash_addr, input, 16 bits: word address of hash word 0; it is sampled when start is accepted.
REQ-007 The block SHALL have port target, input, 32 bits: difficulty threshold; it is sampled when start is accepted.
REQ-008 The block SHALL have ports mem_clk (output, 1 bit, equal to clk), mem_we (output, 1 bit, constant 0) and mem_addr (output, 16 bits, registered).
REQ-009 The block SHALL have port mem_read_data, input, 32 bits: synchronous memory read data.
REQ-010 The block SHALL have result outputs done (1), found (1), nonce_idx (IDX_W), min_hash (32) and min_idx (IDX_W), all registered.

Function
REQ-011 The state machine SHALL have the states IDLE, ADDR, WAIT, CMP and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL on that edge:
- latch hash_addr and target;
- set idx=0, found=0, nonce_idx=0, min_hash=0xFFFFFFFF, min_idx=0 and done=0;
- move to ADDR.
REQ-013 In ADDR, mem_addr SHALL be set to hash_addr+idx, mod 2^16 (wraps past 0xFFFF), and the state SHALL move to WAIT.
REQ-014 WAIT SHALL hold mem_addr for one cycle and then move to CMP.
REQ-015 In CMP, mem_read_data SHALL be taken as hash word idx and compared unsigned; ties do not update (lowest index wins):
- if word < target (strict) and found=0: found<=1 and nonce_idx<=idx;
- if word < min_hash (strict): min_hash<=word and min_idx<=idx.
REQ-016 From CMP, if idx==NUM_NONCES-1 the state SHALL move to DONE with done<=1; otherwise idx<=idx+1 and the state SHALL return to ADDR.
REQ-017 Word k SHALL be compared at edge 3k+3 after the start edge (edge 0); done SHALL rise at edge 3*NUM_NONCES (48 for the default).
REQ-018 The scan SHALL never terminate early; all NUM_NONCES words are read.
REQ-019 done and the result outputs SHALL hold their values in DONE until the next accepted start or reset.
REQ-020 start SHALL be ignored in ADDR, WAIT and CMP; changes to hash_addr and target during a run SHALL have no effect.
REQ-021 mem_we SHALL never be 1.

Reset
REQ-022 While reset=1, the block SHALL immediately force state=IDLE, done=0, found=0, nonce_idx=0, min_hash=0, min_idx=0, mem_addr=0 and idx=0, regardless of clk.
REQ-023 Reset asserted mid-run SHALL abort the run with no partial result retained.
REQ-024 After reset, the first start SHALL behave exactly as in REQ-012.

Verification
REQ-025 All words 0xFFFFFFFF, target 0x00010000, start -> done at edge 48, found=0, nonce_idx=0, min_hash=0xFFFFFFFF, min_idx=0.
REQ-026 Word5=0x0000FFFF, word9=0x00000001, other words 0x80000000, target 0x00010000 -> found=1, nonce_idx=5, min_hash=0x00000001, min_idx=9.
REQ-027 Word3=target=0x00001000, all other words larger -> found=0, min_hash=0x00001000, min_idx=3 (strict compare).
REQ-028 hash_addr=0xFFF8 -> mem_addr sequence 0xFFF8..0xFFFF then 0x0000..0x0007, each address held 2 cycles within its 3-cycle slot; mem_we=0 throughout.
REQ-029 Reset pulsed at edge 20 of a run -> all outputs 0 and state IDLE immediately; a following start completes correctly 48 edges later.
REQ-030 start pulses at edges 5 and 30 of a run are ignored (done still at edge 48); start in DONE clears done on that edge and a second run gives correct results.
